sm_ascii_trace: RTL and testbench

//   Parametrised debug monitor for one state-machine register. Decodes the

---
 rtl/sm_ascii_trace.sv | 144 ++++++++++++++
 tb/tb_sm_ascii_trace.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sm_ascii_trace.sv
// Debug monitor for one FSM state register: registered ASCII decode of the
// state plus a timestamped transition history FIFO drained over valid/ready.
module sm_ascii_trace #(
  parameter int STATE_W    = 3,
  parameter int NUM_STATES = 8,
  parameter int NAME_CHARS = 6,
  parameter logic [NUM_STATES*NAME_CHARS*8-1:0] NAME_TABLE = '0,
  parameter int DEPTH      = 8,
  parameter int TS_W       = 16
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en_i,
  input  logic                         clr_i,
  input  logic [STATE_W-1:0]           state_i,
  output logic [NAME_CHARS*8-1:0]      ascii_o,
  output logic                         ascii_err_o,
  output logic                         trc_valid_o,
  input  logic                         trc_ready_i,
  output logic [TS_W-1:0]              trc_ts_o,
  output logic [STATE_W-1:0]           trc_from_o,
  output logic [STATE_W-1:0]           trc_to_o,
  output logic [$clog2(DEPTH+1)-1:0]   trc_count_o,
  output logic                         ovf_o
);

  localparam int NAME_W = NAME_CHARS * 8;
  localparam int PTR_W  = $clog2(DEPTH);
  localparam int CNT_W  = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [TS_W-1:0]    ts;
    logic [STATE_W-1:0] from_s;
    logic [STATE_W-1:0] to_s;
  } entry_t;

  // "%Error" right-aligned, left-padded with spaces to the name width.
  function automatic logic [NAME_W-1:0] err_name();
    logic [47:0]       tag;
    logic [NAME_W-1:0] r;
    tag = "%Error";
    r   = '0;
    for (int i = 0; i < NAME_CHARS; i++)
      r[i*8 +: 8] = (i < 6) ? tag[i*8 +: 8] : 8'h20;
    return r;
  endfunction

  localparam logic [NAME_W-1:0] ERR_NAME = err_name();

  // ---------------------------------------------------------------- decode
  logic [NAME_W-1:0] name_lookup;
  logic              name_legal;

  // NOTE: every signal written in always_comb gets a default first, otherwise
  // any path that skips the assignment infers a latch.
  always_comb begin
    name_lookup = '0;
    name_legal  = 1'b0;
    for (int k = 0; k < NUM_STATES; k++) begin
      if (state_i == STATE_W'(k)) begin
        name_lookup = NAME_TABLE[k*NAME_W +: NAME_W];
        name_legal  = 1'b1;
      end
    end
    if (name_lookup == '0) name_legal = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ascii_o     <= '0;
      ascii_err_o <= 1'b0;
    end else begin
      ascii_o     <= name_legal ? name_lookup : ERR_NAME;
      ascii_err_o <= ~name_legal;
    end
  end

  // ----------------------------------------------------------------- trace
  logic [TS_W-1:0]    ts_q;
  logic [STATE_W-1:0] prev_q;
  logic               primed_q;
  entry_t             mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [CNT_W-1:0]   count_q;
  logic               ovf_q;

  logic push, pop, full, do_write, drop;

  assign push     = primed_q & en_i & (state_i != prev_q);
  assign pop      = trc_valid_o & trc_ready_i;
  assign full     = (count_q == CNT_W'(DEPTH));
  assign do_write = push & (~full | pop);
  assign drop     = push & full & ~pop;

  // NOTE: the small history array is reset so the head outputs read zero out
  // of reset and no stale entry survives a mid-run reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ts_q     <= '0;
      prev_q   <= '0;
      primed_q <= 1'b0;
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else begin
      prev_q <= state_i;
      if (clr_i) begin
        ts_q     <= '0;
        primed_q <= 1'b0;
        wr_ptr   <= '0;
        rd_ptr   <= '0;
        count_q  <= '0;
        ovf_q    <= 1'b0;
      end else begin
        primed_q <= 1'b1;
        if (en_i) ts_q <= ts_q + 1'b1;
        if (do_write) begin
          mem[wr_ptr] <= '{ts: ts_q, from_s: prev_q, to_s: state_i};
          wr_ptr      <= wr_ptr + 1'b1;
        end
        if (pop) rd_ptr <= rd_ptr + 1'b1;
        // Full push+pop writes the slot being vacated, so the count holds.
        case ({do_write, pop})
          2'b10:   count_q <= count_q + 1'b1;
          2'b01:   count_q <= count_q - 1'b1;
          default: count_q <= count_q;
        endcase
        if (drop) ovf_q <= 1'b1;
      end
    end
  end

  assign trc_valid_o = (count_q != '0);
  assign trc_ts_o    = mem[rd_ptr].ts;
  assign trc_from_o  = mem[rd_ptr].from_s;
  assign trc_to_o    = mem[rd_ptr].to_s;
  assign trc_count_o = count_q;
  assign ovf_o       = ovf_q;

endmodule

// File: tb/tb_sm_ascii_trace.sv
// Bench for sm_ascii_trace: directed scenarios plus random traffic, checked by
// a scoreboard fed from a transaction-level model of the monitor.
module tb_sm_ascii_trace;

  localparam int STATE_W    = 3;
  localparam int NUM_STATES = 8;
  localparam int NC         = 7;
  localparam int DEPTH      = 8;
  localparam int TS_W       = 4;
  localparam logic [NUM_STATES*NC*8-1:0] TABLE = {
    56'("zot"), 56'("rst"), 56'("halt"), 56'("done"),
    56'h0,      56'("wait"), 56'("run"), 56'("idl")};

  logic                   clk, rst_n, en_i, clr_i, trc_ready_i;
  logic [STATE_W-1:0]     state_i;
  logic [NC*8-1:0]        ascii_o;
  logic                   ascii_err_o, trc_valid_o, ovf_o;
  logic [TS_W-1:0]        trc_ts_o;
  logic [STATE_W-1:0]     trc_from_o, trc_to_o;
  logic [$clog2(DEPTH+1)-1:0] trc_count_o;

  sm_ascii_trace #(
    .STATE_W(STATE_W), .NUM_STATES(NUM_STATES), .NAME_CHARS(NC),
    .NAME_TABLE(TABLE), .DEPTH(DEPTH), .TS_W(TS_W)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en_i(en_i), .clr_i(clr_i), .state_i(state_i),
    .ascii_o(ascii_o), .ascii_err_o(ascii_err_o), .trc_valid_o(trc_valid_o),
    .trc_ready_i(trc_ready_i), .trc_ts_o(trc_ts_o), .trc_from_o(trc_from_o),
    .trc_to_o(trc_to_o), .trc_count_o(trc_count_o), .ovf_o(ovf_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------ reference
  string names [NUM_STATES] = '{"idl", "run", "wait", "", "done", "halt", "rst", "zot"};

  function automatic logic [NC*8-1:0] name_bits(input string s);
    logic [NC*8-1:0] r = '0;
    for (int i = 0; i < s.len(); i++) r = {r[NC*8-9:0], s[i]};
    return r;
  endfunction

  function automatic logic [NC*8-1:0] exp_name(input int st);
    string e = "%Error";
    if (names[st] != "") return name_bits(names[st]);
    while (e.len() < NC) e = {" ", e};
    return name_bits(e);
  endfunction

  typedef struct { int ts; int from_s; int to_s; } ent_t;
  ent_t exp_q [$];

  // Model state after the upcoming edge, and the snapshot the DUT shows now.
  int              m_count, m_ts, m_prev;
  bit              m_ovf, m_primed, m_err;
  logic [NC*8-1:0] m_ascii;
  int              cur_count;
  bit              cur_ovf, cur_err;
  logic [NC*8-1:0] cur_ascii = '0;

  task automatic model_apply(input bit en, input bit clr, input int st, input bit rdy);
    bit push, pop;
    m_ascii = exp_name(st);
    m_err   = (names[st] == "");
    if (clr) begin
      m_count = 0; m_ovf = 0; m_ts = 0; m_primed = 0;
      exp_q.delete();
    end else begin
      push = m_primed && en && (st != m_prev);
      pop  = (m_count > 0) && rdy;
      if (pop) m_count--;
      if (push) begin
        if (m_count < DEPTH) begin
          m_count++;
          exp_q.push_back('{m_ts, m_prev, st});
        end else m_ovf = 1;
      end
      if (en) m_ts = (m_ts + 1) % (1 << TS_W);
      m_primed = 1;
    end
    m_prev = st;
  endtask

  task automatic snapshot();
    cur_count = m_count; cur_ovf = m_ovf; cur_ascii = m_ascii; cur_err = m_err;
  endtask

  task automatic step(input bit en, input bit clr, input int st, input bit rdy);
    @(posedge clk); #1;
    snapshot();
    en_i = en; clr_i = clr; state_i = STATE_W'(st); trc_ready_i = rdy;
    model_apply(en, clr, st, rdy);
  endtask

  task automatic do_reset(input int st, input bit en);
    #1;
    rst_n = 1'b0;
    en_i = en; clr_i = 1'b0; state_i = STATE_W'(st); trc_ready_i = 1'b0;
    m_count = 0; m_ovf = 0; m_ts = 0; m_primed = 0; m_prev = 0;
    m_ascii = '0; m_err = 0;
    snapshot();
    exp_q.delete();
    #1;
    check("rst_ascii", ascii_o, 0);
    check("rst_err", ascii_err_o, 0);
    check("rst_valid", trc_valid_o, 0);
    check("rst_count", trc_count_o, 0);
    check("rst_ovf", ovf_o, 0);
    check("rst_head", {trc_ts_o, trc_from_o, trc_to_o}, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    model_apply(en, 1'b0, st, 1'b0);
  endtask

  // -------------------------------------------------------------- monitor
  initial begin
    forever begin
      @(negedge clk);
      check("count", trc_count_o, cur_count);
      check("ovf", ovf_o, cur_ovf);
      check("valid", trc_valid_o, cur_count != 0);
      check("ascii", ascii_o, cur_ascii);
      check("ascii_err", ascii_err_o, cur_err);
      if (rst_n && trc_valid_o && !clr_i) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL head: got valid entry ts=%0h want no entry", trc_ts_o);
        end else begin
          check("head_ts", trc_ts_o, exp_q[0].ts);
          check("head_from", trc_from_o, exp_q[0].from_s);
          check("head_to", trc_to_o, exp_q[0].to_s);
          if (trc_ready_i) void'(exp_q.pop_front());
        end
      end
    end
  end

  // ------------------------------------------------------------- stimulus
  initial begin
    int st;
    rst_n = 1'b0; en_i = 0; clr_i = 0; state_i = '0; trc_ready_i = 0;

    // Decode: legal name, then an empty name that must decode as the error text.
    do_reset(0, 0);
    step(0, 0, 6, 0);
    step(0, 0, 3, 0);
    check("t1_rst_name", ascii_o, 56'("rst"));
    check("t1_rst_err", ascii_err_o, 0);
    step(0, 0, 0, 0);
    check("t1_err_name", ascii_o, 56'(" %Error"));
    check("t1_err_flag", ascii_err_o, 1);

    // First clock after reset never logs, even though prev_q differs.
    do_reset(5, 1);
    step(1, 0, 5, 0);
    step(1, 0, 5, 0);
    check("t2_no_first_log", trc_count_o, 0);

    // 0 -> 6 at ts = 5.
    do_reset(0, 0);
    for (int i = 0; i < 5; i++) step(1, 0, 0, 0);
    step(1, 0, 6, 0);
    step(1, 0, 6, 0);
    step(1, 0, 6, 0);
    check("t2_count", trc_count_o, 1);
    check("t2_entry", {trc_ts_o, trc_from_o, trc_to_o}, {4'd5, 3'd0, 3'd6});
    step(1, 0, 6, 1);

    // Overflow: 10 transitions into an 8-deep FIFO, then drain in order.
    do_reset(0, 1);
    for (int i = 0; i < 10; i++) step(1, 0, (i + 1) % 8, 0);
    step(1, 0, 2, 0);
    step(1, 0, 2, 0);
    check("t3_count", trc_count_o, 8);
    check("t3_ovf", ovf_o, 1);
    for (int i = 0; i < 8; i++) step(1, 0, 2, 1);
    step(1, 0, 2, 0);
    step(1, 0, 2, 0);
    check("t3_drained", trc_count_o, 0);

    // Full FIFO with simultaneous push and pop.
    do_reset(0, 1);
    for (int i = 0; i < 8; i++) step(1, 0, (i + 1) % 8, 0);
    step(1, 0, 4, 1);
    step(1, 0, 4, 0);
    step(1, 0, 4, 0);
    check("t4_count", trc_count_o, 8);
    check("t4_ovf", ovf_o, 0);
    for (int i = 0; i < 8; i++) step(1, 0, 4, 1);

    // Timestamp wrap: transition at cycle 17 with a 4-bit ts logs ts = 1.
    do_reset(0, 0);
    for (int i = 0; i < 20; i++) step(1, 0, (i >= 17) ? 7 : 0, 0);
    step(1, 0, 7, 0);
    check("t5_ts_wrap", trc_ts_o, 1);
    check("t5_to", trc_to_o, 7);

    // clr with 3 entries and overflow set; transition in the clr cycle dropped.
    do_reset(0, 1);
    for (int i = 0; i < 9; i++) step(1, 0, (i + 1) % 8, 0);
    for (int i = 0; i < 6; i++) step(1, 0, 1, (i < 5));
    check("t6_pre_count", trc_count_o, 3);
    check("t6_pre_ovf", ovf_o, 1);
    step(1, 1, 5, 1);
    step(1, 0, 5, 0);
    check("t6_count", trc_count_o, 0);
    check("t6_ovf", ovf_o, 0);
    check("t6_valid", trc_valid_o, 0);
    step(1, 0, 6, 0);
    step(1, 0, 6, 0);
    // ts restarted at 0 on clr and advanced once while re-priming.
    check("t6_ts_restart", trc_ts_o, 1);
    check("t6_entry", {trc_from_o, trc_to_o}, {3'd5, 3'd6});

    // Random traffic with a mid-run asynchronous reset.
    do_reset(0, 1);
    st = 0;
    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(3) == 0) st = $urandom_range(7);
      if (i == 400) do_reset($urandom_range(7), 1);
      step($urandom_range(7) != 0, $urandom_range(59) == 0, st,
           (i % 200 < 60) ? ($urandom_range(5) == 0) : ($urandom_range(2) != 0));
    end
    for (int i = 0; i < 12; i++) step(1, 0, st, 1);
    step(1, 0, st, 1);
    check("final_drained", trc_count_o, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
